seed_role_encoder: RTL

Inverse of the role-seed lookup. Takes a packed 10-bit role vector for 5 players, scans one player per cycle, validates that exactly one wolf and one doctor are present, and returns the 5-bit seed index that produces that vector. The game controller uses it to check role assignments entered by hand or restored from a save, and to regenerate the seed for replay.

---
 rtl/seed_role_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seed_role_encoder.sv
// Inverse role-seed lookup: scans a packed 5-player role vector one player per
// cycle and returns the seed index (0..19) that produces it, or an invalid marker.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   SCAN  | examining one player per cycle, idx 0..4
//   CALC  | legality check and seed arithmetic; results load on exit
module seed_role_encoder (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic [9:0] roles_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       valid_o,
  output logic [4:0] seed_o,
  output logic [2:0] wolf_id_o,
  output logic [2:0] doctor_id_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CALC = 2'd2
  } state_t;

  state_t     state_q;
  logic [9:0] roles_q;
  logic [2:0] idx_q;
  logic [1:0] wolf_cnt_q;
  logic [1:0] doc_cnt_q;
  logic       illegal_q;
  logic [2:0] wolf_idx_q;
  logic [2:0] doc_idx_q;

  logic       busy_q;
  logic       done_q;
  logic       valid_q;
  logic [4:0] seed_q;
  logic [2:0] wolf_id_q;
  logic [2:0] doctor_id_q;

  logic       valid_d;
  logic [4:0] seed_d;
  logic [2:0] wolf_id_d;
  logic [2:0] doctor_id_d;
  logic [4:0] doc_rank;

  // The doctor can never share the wolf's slot, so its rank among the
  // remaining four players drops by one once it sits past the wolf.
  always_comb begin
    valid_d     = (wolf_cnt_q == 2'd1) && (doc_cnt_q == 2'd1) && !illegal_q;
    doc_rank    = (doc_idx_q < wolf_idx_q) ? {2'b00, doc_idx_q}
                                           : ({2'b00, doc_idx_q} - 5'd1);
    seed_d      = 5'd31;
    wolf_id_d   = 3'd7;
    doctor_id_d = 3'd7;
    if (valid_d) begin
      seed_d      = {wolf_idx_q, 2'b00} + doc_rank;
      wolf_id_d   = wolf_idx_q;
      doctor_id_d = doc_idx_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      roles_q     <= '0;
      idx_q       <= '0;
      wolf_cnt_q  <= '0;
      doc_cnt_q   <= '0;
      illegal_q   <= 1'b0;
      wolf_idx_q  <= '0;
      doc_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      seed_q      <= '0;
      wolf_id_q   <= '0;
      doctor_id_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            roles_q    <= roles_i;
            idx_q      <= '0;
            wolf_cnt_q <= '0;
            doc_cnt_q  <= '0;
            illegal_q  <= 1'b0;
            wolf_idx_q <= '0;
            doc_idx_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          // Current player always sits in the top two bits; shift left per step.
          case (roles_q[9:8])
            2'b01: begin
              if (wolf_cnt_q != 2'd2) wolf_cnt_q <= wolf_cnt_q + 2'd1;
              wolf_idx_q <= idx_q;
            end
            2'b10: begin
              if (doc_cnt_q != 2'd2) doc_cnt_q <= doc_cnt_q + 2'd1;
              doc_idx_q <= idx_q;
            end
            2'b11:   illegal_q <= 1'b1;
            default: ;
          endcase
          roles_q <= {roles_q[7:0], 2'b00};
          if (idx_q == 3'd4) begin
            state_q <= CALC;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        CALC: begin
          valid_q     <= valid_d;
          seed_q      <= seed_d;
          wolf_id_q   <= wolf_id_d;
          doctor_id_q <= doctor_id_d;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign valid_o     = valid_q;
  assign seed_o      = seed_q;
  assign wolf_id_o   = wolf_id_q;
  assign doctor_id_o = doctor_id_q;

endmodule
